ex_md_unit: RTL and testbench

Multi-cycle RV32M multiply/divide execution unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the registered `md_sel`/`md_operand_a`/`md_operand_b`/`md_operate` fields and returns a 32-bit result. While an operation is in flight it raises a stall request to the pipeline controller, which holds the ID/EX register stable until the result is ready.

---
 rtl/ex_md_unit_if.sv | 34 +++
 rtl/ex_md_unit.sv | 136 +++++++++++++
 tb/tb_ex_md_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_md_unit_if.sv
// ex_md_unit_if: op encoding package and the ID/EX-side bus of the multiply/divide unit.
package milano_pkg;
  typedef enum logic [3:0] {
    MD_OP_NONE,
    MD_OP_MUL,
    MD_OP_MULH,
    MD_OP_MULHSU,
    MD_OP_MULHU,
    MD_OP_DIV,
    MD_OP_DIVU,
    MD_OP_REM,
    MD_OP_REMU
  } md_opt_e;
endpackage

interface ex_md_unit_if;
  logic                md_sel_i;
  milano_pkg::md_opt_e md_operate_i;
  logic [31:0]         md_operand_a_i;
  logic [31:0]         md_operand_b_i;
  logic                flush_i;
  logic                md_stall_o;
  logic                md_done_o;
  logic [31:0]         md_result_o;
  logic                md_illegal_o;
  modport master (
    output md_sel_i, md_operate_i, md_operand_a_i, md_operand_b_i, flush_i,
    input  md_stall_o, md_done_o, md_result_o, md_illegal_o
  );
  modport slave (
    input  md_sel_i, md_operate_i, md_operand_a_i, md_operand_b_i, flush_i,
    output md_stall_o, md_done_o, md_result_o, md_illegal_o
  );
endinterface

// File: rtl/ex_md_unit.sv
// ex_md_unit: multi-cycle RV32M multiply/divide EX unit; the radix-2 divider
// is built only when MILANO_MD_DIV_EN is defined, otherwise divides report illegal.
module ex_md_unit
  import milano_pkg::*;
(
  input logic         clk_i,
  input logic         rst_i,
  ex_md_unit_if.slave md
);
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;
  state_e             state_q, state_d;
  md_opt_e            op;
  logic [31:0]        result_q, result_d, a, b;
  logic [32:0]        a33, b33;
  logic signed [63:0] prod;
  logic               req, is_mul;
  assign op     = md.md_operate_i;
  assign a      = md.md_operand_a_i;
  assign b      = md.md_operand_b_i;
  assign req    = md.md_sel_i && op != MD_OP_NONE;
  assign is_mul = op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU};
  // 33-bit extension lets one signed multiplier serve all four MUL flavours
  assign a33  = {(op == MD_OP_MULH || op == MD_OP_MULHSU) && a[31], a};
  assign b33  = {op == MD_OP_MULH && b[31], b};
  assign prod = $signed(a33) * $signed(b33);
`ifdef MILANO_MD_DIV_EN
  logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, diff, quo_n, rem_n;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] shl;
  logic        neg_q_q, neg_q_d, neg_r_q, neg_r_d, sel_rem_q, sel_rem_d;
  logic        sdiv, is_rem, ge;
  assign sdiv   = op == MD_OP_DIV || op == MD_OP_REM;
  assign is_rem = op == MD_OP_REM || op == MD_OP_REMU;
  // quotient bits shift in where dividend bits shift out
  assign shl    = {rem_q, quo_q[31]};
  assign ge     = shl >= {1'b0, dvs_q};
  assign diff   = shl[31:0] - dvs_q;
  assign rem_n  = ge ? diff : shl[31:0];
  assign quo_n  = {quo_q[30:0], ge};
  assign md.md_illegal_o = 1'b0;
`else
  logic illegal_q, illegal_d;
  assign md.md_illegal_o = illegal_q;
`endif
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
`ifdef MILANO_MD_DIV_EN
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    sel_rem_d = sel_rem_q;
`else
    illegal_d = illegal_q;
`endif
    if (md.flush_i) state_d = S_IDLE;
    else if (state_q == S_DONE) state_d = S_IDLE;
    else if (state_q == S_IDLE && req) begin
      state_d = S_DONE;
      if (is_mul) begin
        result_d = op == MD_OP_MUL ? prod[31:0] : prod[63:32];
`ifndef MILANO_MD_DIV_EN
        illegal_d = 1'b0;
`endif
      end
`ifdef MILANO_MD_DIV_EN
      else if (b == '0) result_d = is_rem ? a : '1;
      else if (sdiv && a == 32'h8000_0000 && b == '1) result_d = is_rem ? '0 : 32'h8000_0000;
      else begin
        state_d   = S_DIV;
        quo_d     = sdiv && a[31] ? -a : a;
        dvs_d     = sdiv && b[31] ? -b : b;
        rem_d     = '0;
        cnt_d     = 6'd32;
        neg_q_d   = sdiv && (a[31] ^ b[31]);
        neg_r_d   = sdiv && a[31];
        sel_rem_d = is_rem;
      end
`else
      else begin
        result_d  = '0;
        illegal_d = 1'b1;
      end
`endif
    end
`ifdef MILANO_MD_DIV_EN
    else if (state_q == S_DIV) begin
      quo_d = quo_n;
      rem_d = rem_n;
      cnt_d = cnt_q - 6'd1;
      if (cnt_q == 6'd1) begin
        state_d  = S_DONE;
        result_d = sel_rem_q ? (neg_r_q ? -rem_n : rem_n) : (neg_q_q ? -quo_n : quo_n);
      end
    end
`endif
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      result_q <= '0;
`ifdef MILANO_MD_DIV_EN
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      sel_rem_q <= 1'b0;
`else
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
`ifdef MILANO_MD_DIV_EN
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      sel_rem_q <= sel_rem_d;
`else
      illegal_q <= illegal_d;
`endif
    end
  end
  // reset gating keeps stall low while ID/EX still presents a held request
  assign md.md_stall_o  = !rst_i && !md.flush_i && (state_q == S_DIV || (state_q == S_IDLE && req));
  assign md.md_done_o   = state_q == S_DONE && !md.flush_i;
  assign md.md_result_o = result_q;
endmodule

// File: tb/tb_ex_md_unit.sv
// tb_ex_md_unit: vector table, random ops against an arithmetic reference model,
// plus flush and asynchronous-reset sequences; follows MILANO_MD_DIV_EN.
module tb_ex_md_unit;
  import milano_pkg::*;
  typedef struct {
    md_opt_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    logic        ill;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  ex_md_unit_if bus();
  ex_md_unit dut (.clk_i(clk), .rst_i(rst), .md(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", tag, field, act, exp);
    end
  endtask

  function automatic void model(input md_opt_e op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat, output logic ill);
    longint ea, eb, p;
    int sa, sb;
    logic sgn, rm;
    ill = 1'b0;
    lat = 1;
    if (op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU}) begin
      ea = (op == MD_OP_MULH || op == MD_OP_MULHSU) ? longint'($signed(a)) : longint'({32'h0, a});
      eb = (op == MD_OP_MULH) ? longint'($signed(b)) : longint'({32'h0, b});
      p  = ea * eb;
      r  = (op == MD_OP_MUL) ? p[31:0] : p[63:32];
    end else begin
`ifdef MILANO_MD_DIV_EN
      sgn = op == MD_OP_DIV || op == MD_OP_REM;
      rm  = op == MD_OP_REM || op == MD_OP_REMU;
      sa  = $signed(a);
      sb  = $signed(b);
      if (b == 32'h0) r = rm ? a : 32'hFFFF_FFFF;
      else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = rm ? 32'h0 : 32'h8000_0000;
      else begin
        lat = 33;
        if (sgn) r = rm ? 32'(sa % sb) : 32'(sa / sb);
        else r = rm ? a % b : a / b;
      end
`else
      sgn = 1'b0;
      rm  = 1'b0;
      sa  = 0;
      sb  = 0;
      r   = 32'h0;
      ill = 1'b1;
`endif
    end
  endfunction

  // Request in cycle 0 (current), wait for done, then one idle cycle so the next call is back-to-back.
  task automatic run_op(input md_opt_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input int el, input logic ei, input string tag);
    int   lat = 0;
    logic stall_ok = 1'b1;
    bus.md_sel_i       = 1'b1;
    bus.md_operate_i   = op;
    bus.md_operand_a_i = a;
    bus.md_operand_b_i = b;
    #1 chk(tag, "stall_c0", 32'(bus.md_stall_o), 32'd1);
    do begin
      @(posedge clk);
      #1 lat++;
      if (!bus.md_done_o && !bus.md_stall_o) stall_ok = 1'b0;
    end while (!bus.md_done_o && lat < 40);
    chk(tag, "latency", 32'(lat), 32'(el));
    chk(tag, "stall_held", 32'(stall_ok), 32'd1);
    chk(tag, "stall_done", 32'(bus.md_stall_o), 32'd0);
    chk(tag, "result", bus.md_result_o, er);
    chk(tag, "illegal", 32'(bus.md_illegal_o), 32'(ei));
    bus.md_sel_i     = 1'b0;
    bus.md_operate_i = MD_OP_NONE;
    @(posedge clk);
    #1 chk(tag, "done_pulse", 32'(bus.md_done_o), 32'd0);
  endtask

  task automatic run_model(input md_opt_e op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] r;
    int          l;
    logic        il;
    model(op, a, b, r, l, il);
    run_op(op, a, b, r, l, il, tag);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  ro;
    logic        no_done;
    bus.md_sel_i       = 1'b0;
    bus.md_operate_i   = MD_OP_NONE;
    bus.md_operand_a_i = '0;
    bus.md_operand_b_i = '0;
    bus.flush_i        = 1'b0;
`ifdef MILANO_MD_DIV_EN
    vecs.push_back('{MD_OP_DIV,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33, 1'b0});
    vecs.push_back('{MD_OP_REM,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33, 1'b0});
    vecs.push_back('{MD_OP_DIVU, 32'h5,         32'h0,         32'hFFFF_FFFF, 1,  1'b0});
    vecs.push_back('{MD_OP_REMU, 32'h5,         32'h0,         32'h5,         1,  1'b0});
    vecs.push_back('{MD_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0});
    vecs.push_back('{MD_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1,  1'b0});
    vecs.push_back('{MD_OP_DIVU, 32'd100,       32'd7,         32'd14,        33, 1'b0});
`else
    vecs.push_back('{MD_OP_DIV,  32'd10,        32'd2,         32'h0,         1,  1'b1});
    vecs.push_back('{MD_OP_REMU, 32'd5,         32'd0,         32'h0,         1,  1'b1});
`endif
    vecs.push_back('{MD_OP_MUL,    32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 1'b0});
    vecs.push_back('{MD_OP_MULH,   32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1, 1'b0});
    vecs.push_back('{MD_OP_MULHU,  32'h7,         32'hFFFF_FFFD, 32'h6,         1, 1'b0});
    vecs.push_back('{MD_OP_MULHSU, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 1, 1'b0});
    vecs.push_back('{MD_OP_MUL,    32'd2,         32'd3,         32'd6,         1, 1'b0});
    #2;
    chk("reset", "stall", 32'(bus.md_stall_o), 32'd0);
    chk("reset", "done", 32'(bus.md_done_o), 32'd0);
    chk("reset", "result", bus.md_result_o, 32'd0);
    chk("reset", "illegal", 32'(bus.md_illegal_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, vecs[i].ill, $sformatf("vec%0d_%s", i, vecs[i].op.name()));
    // flush on the request cycle: nothing must start
    bus.md_sel_i       = 1'b1;
    bus.md_operate_i   = MD_OP_MUL;
    bus.md_operand_a_i = 32'd9;
    bus.md_operand_b_i = 32'd9;
    bus.flush_i        = 1'b1;
    #1 chk("flush_req", "stall", 32'(bus.md_stall_o), 32'd0);
    @(posedge clk);
    #1 chk("flush_req", "done", 32'(bus.md_done_o), 32'd0);
    bus.flush_i  = 1'b0;
    bus.md_sel_i = 1'b0;
    @(posedge clk);
    #1 run_op(MD_OP_MUL, 32'd3, 32'd4, 32'd12, 1, 1'b0, "mul_after_flush");
    // flush in the DONE cycle suppresses the done pulse
    bus.md_sel_i       = 1'b1;
    bus.md_operate_i   = MD_OP_MUL;
    bus.md_operand_a_i = 32'd5;
    bus.md_operand_b_i = 32'd6;
    @(posedge clk);
    #1 bus.flush_i = 1'b1;
    #1 chk("flush_done", "done", 32'(bus.md_done_o), 32'd0);
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    bus.md_sel_i = 1'b0;
    chk("flush_done", "done_after", 32'(bus.md_done_o), 32'd0);
    @(posedge clk);
    #1;
`ifdef MILANO_MD_DIV_EN
    // flush mid-divide in cycle 10, new MUL in cycle 11
    bus.md_sel_i       = 1'b1;
    bus.md_operate_i   = MD_OP_DIVU;
    bus.md_operand_a_i = 32'd100;
    bus.md_operand_b_i = 32'd7;
    no_done = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1 if (bus.md_done_o) no_done = 1'b0;
    end
    chk("flush_div", "no_done", 32'(no_done), 32'd1);
    bus.flush_i = 1'b1;
    #1 chk("flush_div", "stall", 32'(bus.md_stall_o), 32'd0);
    chk("flush_div", "done", 32'(bus.md_done_o), 32'd0);
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    chk("flush_div", "done_c11", 32'(bus.md_done_o), 32'd0);
    run_op(MD_OP_MUL, 32'd3, 32'd4, 32'd12, 1, 1'b0, "mul_after_div_flush");
`endif
    // asynchronous reset in cycle 5 with a nonzero result held
    run_op(MD_OP_MUL, 32'd7, 32'd3, 32'd21, 1, 1'b0, "mul_pre_rst");
    bus.md_sel_i = 1'b1;
`ifdef MILANO_MD_DIV_EN
    bus.md_operate_i   = MD_OP_DIV;
    bus.md_operand_a_i = 32'd1000;
    bus.md_operand_b_i = 32'd3;
`else
    bus.md_operate_i   = MD_OP_MUL;
    bus.md_operand_a_i = 32'd7;
    bus.md_operand_b_i = 32'd3;
`endif
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst", "stall", 32'(bus.md_stall_o), 32'd0);
    chk("async_rst", "done", 32'(bus.md_done_o), 32'd0);
    chk("async_rst", "result", bus.md_result_o, 32'd0);
    chk("async_rst", "illegal", 32'(bus.md_illegal_o), 32'd0);
    bus.md_sel_i     = 1'b0;
    bus.md_operate_i = MD_OP_NONE;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 run_model(MD_OP_REMU, 32'd17, 32'd5, "remu_after_rst");
    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(1, 8));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_model(md_opt_e'(ro), ra, rb, $sformatf("rnd%0d_%s", i, md_opt_e'(ro)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
